// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: source encodings, FSM states
// and the captured-instruction entry used by wb_stage_pipe and the EX forwarding mux.
package wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_REG_AW = 3;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_SET  = 2'd2,
    SRC_LINK = 2'd3
  } src_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2,
    ST_HALTED   = 2'd3
  } wb_state_e;

  // The entry is sized for the 16-bit core's datapath and register file.
  typedef struct packed {
    src_sel_e               src_sel;
    logic [WB_DATA_W-1:0]   data;
    logic [WB_REG_AW-1:0]   wr_reg;
    logic                   reg_write;
    logic                   halt;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM -> WB handshake. Valid/ready: a transfer happens on a rising clk edge where
// in_valid && in_ready; while in_valid && !in_ready the master holds every in_* field stable.
interface wb_stage_pipe_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_src_sel;
  logic [DATA_W-1:0] in_alu_result;
  logic              in_set_bit;
  logic [DATA_W-1:0] in_link_pc;
  logic [REG_AW-1:0] in_wr_reg;
  logic              in_reg_write;
  logic              in_halt;

  modport master (
    output in_valid, in_src_sel, in_alu_result, in_set_bit, in_link_pc,
           in_wr_reg, in_reg_write, in_halt,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_src_sel, in_alu_result, in_set_bit, in_link_pc,
           in_wr_reg, in_reg_write, in_halt,
    output in_ready
  );
endinterface

// File: rtl/wb_result_mux.sv
// Combinational 4:1 result select with SET zero-extension; also reused by
// the EX-side forwarding path.
module wb_result_mux
  import wb_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  src_sel_e          src_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              set_bit,
  input  logic [DATA_W-1:0] link_pc,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = alu_result;
    unique case (src_sel)
      SRC_ALU:  result = alu_result;
      SRC_MEM:  result = mem_data;
      SRC_SET:  result = {{(DATA_W-1){1'b0}}, set_bit};
      SRC_LINK: result = link_pc;
      default:  result = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Write-back stage: one-entry register fed by MEM, waits on data memory for loads,
// drives the register-file write port / forwarding bus and a saturating retire count.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  wb_stage_pipe_if.slave    up,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              ld_pend,
  output logic [REG_AW-1:0] ld_pend_reg,
  output logic              halted,
  output logic [CNT_W-1:0]  retired,
  output wb_state_e         dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wb_state_e         state_q, state_nxt;
  wb_entry_t         entry_q;
  logic [CNT_W-1:0]  retired_q;
  logic [REG_AW-1:0] last_addr_q;
  logic [DATA_W-1:0] last_data_q;
  logic              accept;
  logic              mem_fill;
  src_sel_e          in_src;
  src_sel_e          mux_sel;
  logic [DATA_W-1:0] mux_out;

  assign in_src      = src_sel_e'(up.in_src_sel);
  assign up.in_ready = (state_q == ST_IDLE) || (state_q == ST_WRITE);
  assign accept      = up.in_valid && up.in_ready;
  assign mem_fill    = (state_q == ST_WAIT_MEM) && mem_done;

  // While waiting, the mux follows the held entry so a load fill takes the MEM leg.
  assign mux_sel = (state_q == ST_WAIT_MEM) ? entry_q.src_sel : in_src;

  wb_result_mux #(.DATA_W(DATA_W)) u_mux (
    .src_sel    (mux_sel),
    .alu_result (up.in_alu_result),
    .mem_data   (mem_data),
    .set_bit    (up.in_set_bit),
    .link_pc    (up.in_link_pc),
    .result     (mux_out)
  );

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_nxt = (in_src == SRC_MEM) ? ST_WAIT_MEM : ST_WRITE;
      end
      ST_WAIT_MEM: begin
        if (mem_done) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (entry_q.halt)  state_nxt = ST_HALTED;
        else if (accept)   state_nxt = (in_src == SRC_MEM) ? ST_WAIT_MEM : ST_WRITE;
        else               state_nxt = ST_IDLE;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      entry_q     <= '0;
      retired_q   <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        entry_q.src_sel   <= in_src;
        entry_q.data      <= mux_out;
        entry_q.wr_reg    <= up.in_wr_reg;
        entry_q.reg_write <= up.in_reg_write;
        entry_q.halt      <= up.in_halt;
      end else if (mem_fill) begin
        entry_q.data <= mux_out;
      end
      if (state_q == ST_WRITE && retired_q != CNT_MAX) retired_q <= retired_q + 1'b1;
      if (rf_wr_en) begin
        last_addr_q <= entry_q.wr_reg;
        last_data_q <= entry_q.data;
      end
    end
  end

  // Write port shows the live entry only while writing, otherwise the last written value.
  assign rf_wr_en    = (state_q == ST_WRITE) && entry_q.reg_write;
  assign rf_wr_addr  = rf_wr_en ? entry_q.wr_reg : last_addr_q;
  assign rf_wr_data  = rf_wr_en ? entry_q.data   : last_data_q;
  assign ld_pend     = (state_q == ST_WAIT_MEM) && entry_q.reg_write;
  assign ld_pend_reg = entry_q.wr_reg;
  assign halted      = (state_q == ST_HALTED);
  assign retired     = retired_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: directed scenarios plus randomized instruction streams
// checked against an in-order write queue and a retire-count model.
module tb_wb_stage_pipe;
  import wb_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 32;

  logic          clk;
  logic          rst;
  logic          mem_done;
  logic [DW-1:0] mem_data;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic          ld_pend;
  logic [AW-1:0] ld_pend_reg;
  logic          halted;
  logic [CW-1:0] retired;
  wb_state_e     dbg_state;

  wb_stage_pipe_if #(.DATA_W(DW), .REG_AW(AW)) ifc ();

  wb_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .up          (ifc),
    .mem_done    (mem_done),
    .mem_data    (mem_data),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .ld_pend     (ld_pend),
    .ld_pend_reg (ld_pend_reg),
    .halted      (halted),
    .retired     (retired),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  logic [CW-1:0]    exp_ret;
  int               n_checks;
  int               n_errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every register-file write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!rst && rf_wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {45'd0, rf_wr_addr, rf_wr_data}, 64'd0);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {61'd0, rf_wr_addr}, {61'd0, e[AW+DW-1:DW]});
        chk("wr_data", {48'd0, rf_wr_data}, {48'd0, e[DW-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    exp_ret = '0;
  endtask

  task automatic count_retire();
    if (exp_ret != '1) exp_ret = exp_ret + 1'b1;
  endtask

  // Present one instruction, wait for acceptance, and serve the load if it is one.
  task automatic send(input logic [1:0] src, input logic [DW-1:0] val, input logic [AW-1:0] rd,
                      input logic rw, input logic hlt, input int lat);
    logic [DW-1:0] exp_d;
    logic          ok;
    int            tries;
    ifc.in_valid      = 1'b1;
    ifc.in_src_sel    = src;
    ifc.in_alu_result = (src == 2'd0) ? val : DW'($urandom);
    ifc.in_set_bit    = (src == 2'd2) ? val[0] : 1'($urandom);
    ifc.in_link_pc    = (src == 2'd3) ? val : DW'($urandom);
    ifc.in_wr_reg     = rd;
    ifc.in_reg_write  = rw;
    ifc.in_halt       = hlt;
    exp_d = (src == 2'd2) ? {{(DW-1){1'b0}}, val[0]} : val;
    ok = 1'b0;
    tries = 0;
    while (!ok && tries < 20) begin
      @(negedge clk);
      ok = ifc.in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    ifc.in_valid = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      if (rw) exp_q.push_back({rd, exp_d});
      count_retire();
      if (src == 2'd1) begin
        for (int i = 0; i < lat; i++) begin
          chk("ld_pend", {63'd0, ld_pend}, {63'd0, rw});
          chk("ld_pend_reg", {61'd0, ld_pend_reg}, {61'd0, rd});
          chk("ready_in_wait", {63'd0, ifc.in_ready}, 64'd0);
          if (i == lat - 1) begin
            mem_done = 1'b1;
            mem_data = val;
          end else begin
            mem_data = DW'($urandom);
          end
          @(posedge clk);
          #1;
        end
        mem_done = 1'b0;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"},   {63'd0, rf_wr_en},    64'd0);
    chk({tag, "_wr_addr"}, {61'd0, rf_wr_addr},  64'd0);
    chk({tag, "_wr_data"}, {48'd0, rf_wr_data},  64'd0);
    chk({tag, "_ld_pend"}, {63'd0, ld_pend},     64'd0);
    chk({tag, "_ld_reg"},  {61'd0, ld_pend_reg}, 64'd0);
    chk({tag, "_halted"},  {63'd0, halted},      64'd0);
    chk({tag, "_retired"}, {32'd0, retired},     64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_ret  = '0;
    rst      = 1'b1;
    mem_done = 1'b0;
    mem_data = '0;
    ifc.in_valid = 1'b0;
    ifc.in_src_sel = '0;
    ifc.in_alu_result = '0;
    ifc.in_set_bit = 1'b0;
    ifc.in_link_pc = '0;
    ifc.in_wr_reg = '0;
    ifc.in_reg_write = 1'b0;
    ifc.in_halt = 1'b0;
    do_reset();
    check_zero("reset");
    chk("reset_ready", {63'd0, ifc.in_ready}, 64'd1);

    // Back-to-back ALU ops.
    send(2'd0, 16'h1234, 3'd1, 1'b1, 1'b0, 0);
    chk("b2b_ready", {63'd0, ifc.in_ready}, 64'd1);
    send(2'd0, 16'hBEEF, 3'd2, 1'b1, 1'b0, 0);
    chk("b2b_wr_en", {63'd0, rf_wr_en}, 64'd1);
    chk("b2b_retired_1", {32'd0, retired}, 64'd1);
    idle(1);
    chk("b2b_retired_2", {32'd0, retired}, 64'd2);
    chk("hold_wr_en", {63'd0, rf_wr_en}, 64'd0);
    chk("hold_wr_data", {48'd0, rf_wr_data}, 64'hBEEF);
    chk("hold_wr_addr", {61'd0, rf_wr_addr}, 64'd2);

    // SET and LINK.
    send(2'd2, 16'h0001, 3'd3, 1'b1, 1'b0, 0);
    send(2'd3, 16'h0042, 3'd7, 1'b1, 1'b0, 0);
    idle(1);

    // Stray mem_done in IDLE, then a 3-cycle load.
    mem_done = 1'b1;
    mem_data = 16'hFFFF;
    idle(1);
    mem_done = 1'b0;
    idle(1);
    send(2'd1, 16'hA5A5, 3'd4, 1'b1, 1'b0, 3);
    chk("load_wr_en", {63'd0, rf_wr_en}, 64'd1);
    chk("load_wr_data", {48'd0, rf_wr_data}, 64'hA5A5);

    // Load without register write still retires.
    send(2'd1, 16'h7777, 3'd5, 1'b0, 1'b0, 2);
    idle(2);
    chk("retired_directed", {32'd0, retired}, {32'd0, exp_ret});

    // Randomized stream: random sources, load latencies and idle gaps.
    for (int n = 0; n < 150; n++) begin
      send(2'($urandom_range(0, 3)), DW'($urandom), AW'($urandom_range(0, 7)),
           ($urandom_range(0, 4) != 0), 1'b0, $urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    chk("retired_random", {32'd0, retired}, {32'd0, exp_ret});
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // HALT after an ALU write; HALT itself writes.
    send(2'd0, 16'h0BAD, 3'd5, 1'b1, 1'b0, 0);
    send(2'd0, 16'hCAFE, 3'd6, 1'b1, 1'b1, 0);
    chk("halt_not_yet", {63'd0, halted}, 64'd0);
    idle(1);
    chk("halted", {63'd0, halted}, 64'd1);
    chk("halted_ready", {63'd0, ifc.in_ready}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_reg_write = 1'b1;
      ifc.in_src_sel = 2'($urandom_range(0, 3));
      mem_done = 1'b1;
      idle(1);
      chk("halted_sticky", {63'd0, halted}, 64'd1);
      chk("halted_no_wr", {63'd0, rf_wr_en}, 64'd0);
    end
    ifc.in_valid = 1'b0;
    mem_done = 1'b0;
    chk("halted_retired", {32'd0, retired}, {32'd0, exp_ret});
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_ret = '0;
    check_zero("halt_rst");

    // Reset during a load, coincident with mem_done.
    send(2'd0, 16'h1111, 3'd1, 1'b1, 1'b0, 0);
    ifc.in_valid = 1'b1;
    ifc.in_src_sel = 2'd1;
    ifc.in_wr_reg = 3'd2;
    ifc.in_reg_write = 1'b1;
    ifc.in_halt = 1'b0;
    idle(1);
    ifc.in_valid = 1'b0;
    chk("rst_ld_pend", {63'd0, ld_pend}, 64'd1);
    rst = 1'b1;
    mem_done = 1'b1;
    mem_data = 16'h5A5A;
    idle(1);
    rst = 1'b0;
    mem_done = 1'b0;
    exp_ret = '0;
    check_zero("load_rst");
    idle(2);

    // Saturation of the retire counter.
    force dut.retired_q = '1;
    idle(1);
    release dut.retired_q;
    exp_ret = '1;
    send(2'd0, 16'h2222, 3'd3, 1'b1, 1'b0, 0);
    idle(2);
    chk("retired_sat", {32'd0, retired}, {32'd0, exp_ret});
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
